// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES byte type and the FIPS-197 forward / inverse S-box tables used
//   by every SubBytes lane.
//   Contents:
//     byte_t    8-bit byte type
//     SBOX_FWD  forward S-box, indexed by input byte
//     SBOX_INV  inverse S-box, indexed by input byte
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sub_bytes_pipe_if.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_pipe_if
//   Valid/ready byte-lane stream carrying LANES bytes plus a mode tag.
//   Signals:
//     valid  beat valid (source -> sink)
//     ready  sink accepts beat (sink -> source)
//     data   8*LANES bytes, lane i = data[8i+7:8i]
//     inv    mode tag, 1 = inverse S-box beat
//   Modports:
//     master  stream source
//     slave   stream sink
// ---------------------------------------------------------------------------
interface aes_sub_bytes_pipe_if #(
    parameter int LANES = 4
);
    logic               valid;
    logic               ready;
    logic [8*LANES-1:0] data;
    logic               inv;

    modport master (output valid, output data, output inv, input  ready);
    modport slave  (input  valid, input  data, input  inv, output ready);
endinterface

// File: rtl/aes_sbox_lut.sv
// ---------------------------------------------------------------------------
// aes_sbox_lut
//   Combinational single-byte AES S-box lookup.
//   Ports:
//     din   input byte
//     inv   1 = inverse table (present only when AES_SBOX_INV_EN is defined)
//     dout  substituted byte
//   Build option: AES_SBOX_INV_EN adds the inverse table and the inv port.
// ---------------------------------------------------------------------------
module aes_sbox_lut
    import aes_pkg::*;
(
    input  byte_t din,
`ifdef AES_SBOX_INV_EN
    input  logic  inv,
`endif
    output byte_t dout
);

`ifdef AES_SBOX_INV_EN
    assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
`else
    assign dout = SBOX_FWD[din];
`endif

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_pipe
//   Multi-lane pipelined AES SubBytes: LANES bytes per beat, one beat per
//   clock, valid/ready on both sides, two register stages (S1 input capture,
//   S2 substituted result), at most two beats in flight.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     in_bus    input stream (slave): valid/ready/data/inv
//     out_bus   output stream (master): valid/ready/data/inv
//     beat_cnt  count of output transfers, wraps at 2^CNT_W
//   Build option: AES_SBOX_INV_EN enables the per-beat inverse S-box and the
//   out_bus.inv tag; otherwise in_bus.inv is ignored and out_bus.inv is 0.
// ---------------------------------------------------------------------------
module aes_sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_sub_bytes_pipe_if.slave  in_bus,
    aes_sub_bytes_pipe_if.master out_bus,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam int W = 8 * LANES;

    logic         s1_valid;
    logic         s2_valid;
    logic         s1_adv;
    logic         s2_adv;
    logic [W-1:0] s1_data;
    logic [W-1:0] s2_data;
    logic [W-1:0] lut_out;
`ifdef AES_SBOX_INV_EN
    logic         s1_inv;
    logic         s2_inv;
`else
    logic         unused_inv;
    assign unused_inv = in_bus.inv;
`endif

    // A stage may load when it is empty or its content moves on this cycle.
    // in_ready deliberately does not look at in_valid.
    assign s2_adv       = !s2_valid || out_bus.ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign in_bus.ready = s1_adv;

    // ---- S1: input capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_bus.valid;
        end
    end

    // Payload only loads on a real transfer so idle-bus garbage never enters.
    always_ff @(posedge clk) begin
        if (s1_adv && in_bus.valid) begin
            s1_data <= in_bus.data;
`ifdef AES_SBOX_INV_EN
            s1_inv  <= in_bus.inv;
`endif
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lut u_lut (
            .din  (s1_data[8*i +: 8]),
`ifdef AES_SBOX_INV_EN
            .inv  (s1_inv),
`endif
            .dout (lut_out[8*i +: 8])
        );
    end

    // ---- S2: substituted result, held stable while stalled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
`ifdef AES_SBOX_INV_EN
            s2_inv   <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= lut_out;
`ifdef AES_SBOX_INV_EN
                s2_inv  <= s1_inv;
`endif
            end
        end
    end

    assign out_bus.valid = s2_valid;
    assign out_bus.data  = s2_data;
`ifdef AES_SBOX_INV_EN
    assign out_bus.inv   = s2_inv;
`else
    assign out_bus.inv   = 1'b0;
`endif

    // ---- output transfer counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_bus.valid && out_bus.ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_sub_bytes_pipe
//   Self-checking bench for aes_sub_bytes_pipe (LANES=4). Two instances share
//   the same stimulus: CNT_W=16 and CNT_W=4 (counter wrap). The S-box model
//   is derived from GF(2^8) inversion plus the affine transform.
// ---------------------------------------------------------------------------
module tb_aes_sub_bytes_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    aes_sub_bytes_pipe_if #(.LANES(4)) in_a ();
    aes_sub_bytes_pipe_if #(.LANES(4)) out_a ();
    aes_sub_bytes_pipe_if #(.LANES(4)) in_b ();
    aes_sub_bytes_pipe_if #(.LANES(4)) out_b ();

    aes_sub_bytes_pipe #(.LANES(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(in_a), .out_bus(out_a), .beat_cnt(cnt_a)
    );
    aes_sub_bytes_pipe #(.LANES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(in_b), .out_bus(out_b), .beat_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int          nvec  = 0;
    int          nfail = 0;
    logic [7:0]  fwd_tab [256];
    logic [7:0]  inv_tab [256];
    logic [32:0] q [$];
    int unsigned mcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S(x) = affine(x^-1), with 0 mapping to 0 before the affine step.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        if (x == 8'h00) r = 8'h00;
        else for (int k = 0; k < 254; k++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [32:0] exp_beat(input logic [31:0] d, input logic i);
        logic        use_inv;
        logic [31:0] r;
`ifdef AES_SBOX_INV_EN
        use_inv = i;
`else
        use_inv = i & 1'b0;
`endif
        for (int l = 0; l < 4; l++)
            r[8*l +: 8] = use_inv ? inv_tab[d[8*l +: 8]] : fwd_tab[d[8*l +: 8]];
        return {use_inv, r};
    endfunction

    // Inputs change just after the rising edge; returns at the next edge + 1.
    task automatic drive(input logic v, input logic [31:0] d, input logic i,
                         input logic r, output bit acc);
        in_a.valid = v;  in_a.data = d;  in_a.inv = i;  out_a.ready = r;
        in_b.valid = v;  in_b.data = d;  in_b.inv = i;  out_b.ready = r;
        #1;
        acc = v && in_a.ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        bit acc;
        for (int k = 0; k < bound && q.size() != 0; k++) drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Compare process: every falling edge while out of reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            check("in_ready", 64'(in_a.ready), 64'((q.size() < 2) || out_a.ready));
            check("in_ready_b", 64'(in_b.ready), 64'(in_a.ready));
            check("beat_cnt16", 64'(cnt_a), 64'(mcnt[15:0]));
            check("beat_cnt4", 64'(cnt_b), 64'(mcnt[3:0]));
            check("out_valid_b", 64'(out_b.valid), 64'(out_a.valid));
            if (q.size() == 0) check("out_valid_idle", 64'(out_a.valid), 64'd0);
            if (out_a.valid && q.size() != 0) begin
                check("out_data", 64'(out_a.data), 64'(q[0][31:0]));
                check("out_data_b", 64'(out_b.data), 64'(q[0][31:0]));
                check("out_inv", 64'(out_a.inv), 64'(q[0][32]));
                if (out_a.ready) begin
                    void'(q.pop_front());
                    mcnt++;
                end
            end
            if (in_a.valid && in_a.ready) q.push_back(exp_beat(in_a.data, in_a.inv));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          sent;
        int unsigned base;
        logic [31:0] beats [3];

        for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_model(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
        check("model_s00", 64'(fwd_tab[8'h00]), 64'h63);
        check("model_s53", 64'(fwd_tab[8'h53]), 64'hed);
        check("model_sff", 64'(fwd_tab[8'hff]), 64'h16);
        check("model_inv63", 64'(inv_tab[8'h63]), 64'h00);

        in_a.valid = 0; in_a.data = 0; in_a.inv = 0; out_a.ready = 0;
        in_b.valid = 0; in_b.data = 0; in_b.inv = 0; out_b.ready = 0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(out_a.valid), 64'd0);
        check("rst_out_data", 64'(out_a.data), 64'd0);
        check("rst_out_inv", 64'(out_a.inv), 64'd0);
        check("rst_beat_cnt", 64'(cnt_a), 64'd0);
        check("rst_in_ready", 64'(in_a.ready), 64'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, literal expectation and latency.
        drive(1'b1, 32'h000153ff, 1'b0, 1'b1, acc);
        check("t1_accept", 64'(acc), 64'd1);
        check("t1_not_yet", 64'(out_a.valid), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("t1_valid", 64'(out_a.valid), 64'd1);
        check("t1_data", 64'(out_a.data), 64'h637ced16);
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("t1_cnt", 64'(cnt_a), 64'd1);
        check("t1_cnt4", 64'(cnt_b), 64'd1);

        // Exhaustive back-to-back stream, full throughput.
        base = mcnt;
        sent = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, 1'b0, 1'b1, acc);
            sent += int'(acc);
        end
        check("t2_all_accepted", 64'(sent), 64'd256);
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("t2_delivered", 64'(mcnt - base), 64'd256);

        // Back-pressure: three beats against a stalled sink.
        base = mcnt;
        beats[0] = 32'hdeadbeef; beats[1] = 32'h01234567; beats[2] = 32'h89abcdef;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            drive(sent < 3, beats[sent < 3 ? sent : 2], 1'b0, 1'b0, acc);
            sent += int'(acc);
        end
        check("t3_accepted_stalled", 64'(sent), 64'd2);
        check("t3_in_ready_low", 64'(in_a.ready), 64'd0);
        for (int c = 0; c < 10 && sent < 3; c++) begin
            drive(1'b1, beats[2], 1'b0, 1'b1, acc);
            sent += int'(acc);
        end
        check("t3_third_accepted", 64'(sent), 64'd3);
        drain(10);
        check("t3_delivered", 64'(mcnt - base), 64'd3);

`ifdef AES_SBOX_INV_EN
        // Inverse mode and mixed per-beat modes.
        drive(1'b1, 32'h637ced16, 1'b1, 1'b1, acc);
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("t4_inv_data", 64'(out_a.data), 64'h000153ff);
        check("t4_inv_tag", 64'(out_a.inv), 64'd1);
        for (int i = 0; i < 16; i++) drive(1'b1, $urandom, i[0], 1'b1, acc);
        drain(10);
`endif

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 9) < 7, $urandom, 1'($urandom), $urandom_range(0, 9) < 7, acc);
        drain(20);

        // Reset with two beats in flight.
        drive(1'b1, 32'h11223344, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h55667788, 1'b0, 1'b0, acc);
        in_a.valid = 0; in_b.valid = 0;
        check("t5_two_in_flight", 64'(q.size()), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_out_valid_async", 64'(out_a.valid), 64'd0);
        check("t5_cnt_async", 64'(cnt_a), 64'd0);
        check("t5_out_data_async", 64'(out_a.data), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
            check("t5_no_stale", 64'(out_a.valid), 64'd0);
        end

        // Counter wrap on the CNT_W=4 instance: 17 beats -> 1.
        for (int i = 0; i < 17; i++) drive(1'b1, $urandom, 1'b0, 1'b1, acc);
        drain(10);
        drive(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check("t6_cnt4_wrap", 64'(cnt_b), 64'd1);
        check("t6_cnt16", 64'(cnt_a), 64'd17);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
